// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: FSM state encoding shared by the bit-serial add/sub controller
package serial_addsub_pkg;
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] RUN  = 2'd1;
    localparam logic [STATE_W-1:0] DONE = 2'd2;
endpackage

// File: rtl/serial_addsub_ctrl_cell.sv
// addsub_cell: combinational 1-bit full adder that inverts b itself when sub is set
module addsub_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sub,
    output logic cout,
    output logic s
);
    logic bx;
    assign bx   = b ^ sub;
    assign s    = a ^ bx ^ cin;
    assign cout = (a & bx) | (a & cin) | (bx & cin);
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: LSB-first bit-serial add/sub sequencer; SERIAL_ADDSUB_OVF_EN enables signed overflow
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH);
    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh, b_sh, r_sh;
    logic               sub_l, carry, s, co, is_last;
    addsub_cell u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .sub (sub_l),
        .cout(co),
        .s   (s)
    );
    assign is_last = cnt == CNT_W'(WIDTH - 1);
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            sub_l  <= 1'b0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                state <= RUN;
                a_sh  <= a;
                b_sh  <= b;
                sub_l <= sub;
                carry <= sub;
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= {s, r_sh[WIDTH-1:1]};
            carry <= co;
            cnt   <= is_last ? cnt : cnt + 1'b1;
            if (is_last) begin
                state  <= DONE;
                result <= {s, r_sh[WIDTH-1:1]};
                cout   <= co;
            end
        end else begin
            state <= IDLE;
        end
    end
`ifdef SERIAL_ADDSUB_OVF_EN
    // c_msb is the carry leaving bit WIDTH-2, i.e. the carry into the MSB
    logic c_msb;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_msb    <= 1'b0;
            overflow <= 1'b0;
        end else if (state == RUN) begin
            if (cnt == CNT_W'(WIDTH - 2)) c_msb <= co;
            if (is_last) overflow <= c_msb ^ co;
        end
    end
`else
    assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: self-checking bench for serial_addsub_ctrl against an arithmetic model
module tb_serial_addsub_ctrl;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, overflow;
    logic [W-1:0] result;
    int           checks = 0;
    int           failures = 0;
    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .overflow(overflow)
    );
    always #5 clk = ~clk;
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] t;
        logic       v;
        t = s ? {1'b0, x} + {1'b0, ~y} + (W+1)'(1) : {1'b0, x} + {1'b0, y};
        v = s ? (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]) : (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
`ifndef SERIAL_ADDSUB_OVF_EN
        v = 1'b0;
`endif
        return {v, t};
    endfunction
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, output int lat);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, result, cout, overflow} !== '0) begin
            failures++;
            $display("FAIL reset outputs got busy=%b done=%b result=%h cout=%b ovf=%b exp all 0", busy, done, result, cout, overflow);
        end
        rst_n = 1'b1;
    endtask
    task automatic test_directed();
        logic [W-1:0] va [6] = '{8'h05, 8'h05, 8'h03, 8'h7F, 8'hFF, 8'h80};
        logic [W-1:0] vb [6] = '{8'h03, 8'h03, 8'h05, 8'h01, 8'h01, 8'h01};
        logic         vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] er [6] = '{8'h08, 8'h02, 8'hFE, 8'h80, 8'h00, 8'h7F};
        logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef SERIAL_ADDSUB_OVF_EN
        logic         ev [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        logic         ev [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vs[i], lat);
            checks++;
            if (lat !== W + 1) begin
                failures++;
                $display("FAIL directed%0d latency got=%0d exp=%0d", i, lat, W + 1);
            end
            checks++;
            if ({overflow, cout, result} !== {ev[i], ec[i], er[i]}) begin
                failures++;
                $display("FAIL directed%0d got ovf=%b cout=%b result=%h exp ovf=%b cout=%b result=%h",
                         i, overflow, cout, result, ev[i], ec[i], er[i]);
            end
        end
    endtask
    task automatic test_random();
        logic [W-1:0] x, y;
        logic         s;
        logic [W+1:0] exp;
        int lat;
        for (int i = 0; i < 24; i++) begin
            x = W'($urandom); y = W'($urandom); s = 1'($urandom);
            exp = model(x, y, s);
            do_op(x, y, s, lat);
            checks++;
            if (lat !== W + 1 || {overflow, cout, result} !== exp) begin
                failures++;
                $display("FAIL random%0d a=%h b=%h sub=%b got lat=%0d {ovf,cout,res}=%h exp lat=%0d %h",
                         i, x, y, s, lat, {overflow, cout, result}, W + 1, exp);
            end
        end
    endtask
    task automatic test_busy_ignore();
        logic [W+1:0] exp;
        int lat;
        exp = model(8'h21, 8'h34, 1'b0);
        @(negedge clk);
        a = 8'h21; b = 8'h34; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_run got=%b exp=1", busy);
        end
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 3) begin
                a = 8'hF0; b = 8'h0F; sub = 1'b1; start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== W + 1 || {overflow, cout, result} !== exp) begin
            failures++;
            $display("FAIL busy_ignore got lat=%0d %h exp lat=%0d %h", lat, {overflow, cout, result}, W + 1, exp);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL no_queue busy got=%b exp=0", busy);
        end
    endtask
    task automatic test_hold();
        logic [W+1:0] e1, e2;
        int n, t1, t2;
        e1 = model(8'h9C, 8'h47, 1'b1);
        e2 = model(8'h55, 8'h22, 1'b0);
        t1 = -1; t2 = -1;
        @(negedge clk);
        a = 8'h9C; b = 8'h47; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        n = 1;
        while (n < 60 && t2 < 0) begin
            if (n == 2) begin
                a = 8'h55; b = 8'h22; sub = 1'b0;
            end
            if (done === 1'b1 && t1 < 0) begin
                t1 = n;
                checks++;
                if ({overflow, cout, result} !== e1) begin
                    failures++;
                    $display("FAIL hold_first got=%h exp=%h", {overflow, cout, result}, e1);
                end
            end else if (done === 1'b1) begin
                t2 = n;
                start = 1'b0;
                checks++;
                if ({overflow, cout, result} !== e2) begin
                    failures++;
                    $display("FAIL hold_second got=%h exp=%h", {overflow, cout, result}, e2);
                end
            end
            if (t2 < 0) begin
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        checks++;
        if (t1 < 0 || t2 < 0 || t2 - t1 !== W + 2) begin
            failures++;
            $display("FAIL hold_spacing got first=%0d second=%0d exp spacing=%0d", t1, t2, W + 2);
        end
    endtask
    task automatic test_reset_mid();
        logic [W+1:0] exp;
        int lat;
        @(negedge clk);
        @(negedge clk);
        a = 8'h3C; b = 8'hC5; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, cout, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b result=%h cout=%b ovf=%b exp all 0", busy, done, result, cout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp = model(8'h7F, 8'h01, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== W + 1 || {overflow, cout, result} !== exp) begin
            failures++;
            $display("FAIL after_reset got lat=%0d %h exp lat=%0d %h", lat, {overflow, cout, result}, W + 1, exp);
        end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
